// File: rtl/qr_check_monitor.sv
// Synthesizable scoreboard for the valid/q/r/en request rule: a valid cycle
// passes when (q | r) & en, with saturating counters, first-fail timestamp and irq.
module qr_check_monitor #(
    parameter int CNT_W        = 16,
    parameter int TS_W         = 32,
    parameter int FAIL_THRESH  = 3,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             q,
    input  logic             r,
    input  logic             en,
    input  logic             arm,
    input  logic             disarm,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [TS_W-1:0]  cycle_cnt,
    output logic [TS_W-1:0]  first_fail_ts,
    output logic             fail_seen,
    output logic             fail_irq,
    output logic [1:0]       state
);

    localparam logic [1:0]       IDLE   = 2'd0;
    localparam logic [1:0]       RUN    = 2'd1;
    localparam logic [1:0]       HALT   = 2'd2;
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAIL_THRESH);

    logic [CNT_W-1:0] cfail;
    logic [CNT_W-1:0] cfail_nxt;
    logic [1:0]       state_nxt;
    logic             in_run;
    logic             pass_p0;
    logic             fail_p0;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TS_W-1:0] sat_inc_ts(input logic [TS_W-1:0] v);
        return (&v) ? v : v + TS_W'(1);
    endfunction

    // Stage p0: classify the sample; a same-cycle clear discards it
    always_comb begin
        in_run    = (state == RUN);
        pass_p0   = in_run && valid && ((q || r) && en) && !clear;
        fail_p0   = in_run && valid && !((q || r) && en) && !clear;
        cfail_nxt = sat_inc_cnt(cfail);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (arm && !disarm) state_nxt = RUN;
            RUN: begin
                if (disarm)
                    state_nxt = IDLE;
                else if ((STOP_ON_FAIL != 0) && fail_p0)
                    state_nxt = HALT;
            end
            HALT: begin
                if (disarm)
                    state_nxt = IDLE;
                else if (arm)
                    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: registered counters, flags and state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            cfail         <= '0;
            cycle_cnt     <= '0;
            first_fail_ts <= '0;
            fail_seen     <= 1'b0;
            fail_irq      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                pass_cnt      <= '0;
                fail_cnt      <= '0;
                cfail         <= '0;
                cycle_cnt     <= '0;
                first_fail_ts <= '0;
                fail_seen     <= 1'b0;
                fail_irq      <= 1'b0;
            end else if (in_run) begin
                cycle_cnt <= sat_inc_ts(cycle_cnt);
                if (pass_p0) begin
                    pass_cnt <= sat_inc_cnt(pass_cnt);
                    cfail    <= '0;
                end
                if (fail_p0) begin
                    fail_cnt <= sat_inc_cnt(fail_cnt);
                    cfail    <= cfail_nxt;
                    if (!fail_seen) begin
                        first_fail_ts <= cycle_cnt;
                        fail_seen     <= 1'b1;
                    end
                    if (cfail_nxt == THRESH)
                        fail_irq <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qr_check_monitor.sv
// Bench for qr_check_monitor: table-driven vectors through a scoreboard queue on
// three parameterisations (default, stop-on-fail, 4-bit counters) plus async reset.
module tb_qr_check_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0, q = 1'b0, r = 1'b0, en = 1'b0;
    logic arm = 1'b0, disarm = 1'b0, clear = 1'b0;

    logic [15:0] a_pass, a_fail, s_pass, s_fail;
    logic [3:0]  c_pass, c_fail;
    logic [31:0] a_cyc, a_ts, s_cyc, s_ts, c_cyc, c_ts;
    logic        a_seen, a_irq, s_seen, s_irq, c_seen, c_irq;
    logic [1:0]  a_st, s_st, c_st;

    always #5 clk = ~clk;

    qr_check_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .valid(valid), .q(q), .r(r), .en(en),
        .arm(arm), .disarm(disarm), .clear(clear),
        .pass_cnt(a_pass), .fail_cnt(a_fail), .cycle_cnt(a_cyc),
        .first_fail_ts(a_ts), .fail_seen(a_seen), .fail_irq(a_irq), .state(a_st)
    );

    qr_check_monitor #(.STOP_ON_FAIL(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .valid(valid), .q(q), .r(r), .en(en),
        .arm(arm), .disarm(disarm), .clear(clear),
        .pass_cnt(s_pass), .fail_cnt(s_fail), .cycle_cnt(s_cyc),
        .first_fail_ts(s_ts), .fail_seen(s_seen), .fail_irq(s_irq), .state(s_st)
    );

    qr_check_monitor #(.CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .valid(valid), .q(q), .r(r), .en(en),
        .arm(arm), .disarm(disarm), .clear(clear),
        .pass_cnt(c_pass), .fail_cnt(c_fail), .cycle_cnt(c_cyc),
        .first_fail_ts(c_ts), .fail_seen(c_seen), .fail_irq(c_irq), .state(c_st)
    );

    // Input bit positions: arm, disarm, clear, valid, q, r, en
    localparam logic [6:0] ARM = 7'h40, DIS = 7'h20, CLR = 7'h10;
    localparam logic [6:0] V = 7'h08, Q = 7'h04, R = 7'h02, E = 7'h01;

    typedef struct {
        string       name;
        int          sel;
        bit          do_rst;
        logic [6:0]  in;
        logic [99:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [99:0] pack(logic [15:0] p, logic [15:0] f, logic [31:0] c,
                                         logic [31:0] ts, logic s, logic i, logic [1:0] st);
        return {p, f, c, ts, s, i, st};
    endfunction

    function automatic logic [99:0] actual(int sel);
        case (sel)
            0:       return pack(a_pass, a_fail, a_cyc, a_ts, a_seen, a_irq, a_st);
            1:       return pack(s_pass, s_fail, s_cyc, s_ts, s_seen, s_irq, s_st);
            default: return pack({12'd0, c_pass}, {12'd0, c_fail}, c_cyc, c_ts, c_seen, c_irq, c_st);
        endcase
    endfunction

    function automatic void add(string nm, int sel, bit rst, logic [6:0] in,
                                int p, int f, int c, int ts, bit s, bit i, int st);
        vec_t v;
        v.name   = nm;
        v.sel    = sel;
        v.do_rst = rst;
        v.in     = in;
        v.exp    = pack(16'(p), 16'(f), 32'(c), 32'(ts), s, i, 2'(st));
        tbl.push_back(v);
    endfunction

    task automatic check(string nm, logic [99:0] act, logic [99:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pass=%0d fail=%0d cyc=%0d ts=%0d seen=%0b irq=%0b st=%0d, want pass=%0d fail=%0d cyc=%0d ts=%0d seen=%0b irq=%0b st=%0d",
                     nm, act[99:84], act[83:68], act[67:36], act[35:4], act[3], act[2], act[1:0],
                     exp[99:84], exp[83:68], exp[67:36], exp[35:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic drive(logic [6:0] in);
        {arm, disarm, clear, valid, q, r, en} = in;
    endtask

    task automatic do_reset();
        drive(7'h00);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t e;

        // Default configuration: idle, mixed, interrupt, clear, disarm, arm+disarm
        for (int k = 0; k < 5; k++) add("idle_no_arm", 0, k == 0, V, 0, 0, 0, 0, 0, 0, 0);
        add("arm_edge_unclassified", 0, 0, ARM | V | R, 0, 0, 0, 0, 0, 0, 1);
        add("mix_010", 0, 0, V | R,         0, 1, 1, 0, 1, 0, 1);
        add("mix_100", 0, 0, V | Q,         0, 2, 2, 0, 1, 0, 1);
        add("mix_011", 0, 0, V | R | E,     1, 2, 3, 0, 1, 0, 1);
        add("mix_101", 0, 0, V | Q | E,     2, 2, 4, 0, 1, 0, 1);
        add("mix_111", 0, 0, V | Q | R | E, 3, 2, 5, 0, 1, 0, 1);
        add("valid_low", 0, 0, 7'h00,       3, 2, 6, 0, 1, 0, 1);
        add("clear_discards", 0, 0, CLR | V, 0, 0, 0, 0, 0, 0, 1);
        add("irq_f1", 0, 0, V,         0, 1, 1, 0, 1, 0, 1);
        add("irq_f2", 0, 0, V,         0, 2, 2, 0, 1, 0, 1);
        add("irq_p",  0, 0, V | Q | E, 1, 2, 3, 0, 1, 0, 1);
        add("irq_f3", 0, 0, V,         1, 3, 4, 0, 1, 0, 1);
        add("irq_f4", 0, 0, V,         1, 4, 5, 0, 1, 0, 1);
        add("irq_f5", 0, 0, V,         1, 5, 6, 0, 1, 1, 1);
        add("irq_sticky", 0, 0, 7'h00, 1, 5, 7, 0, 1, 1, 1);
        add("clear_in_run", 0, 0, CLR, 0, 0, 0, 0, 0, 0, 1);
        add("disarm_edge_counted", 0, 0, DIS | V | Q | E, 1, 0, 1, 0, 0, 0, 0);
        add("idle_frozen", 0, 0, V | Q | E, 1, 0, 1, 0, 0, 0, 0);
        add("arm_disarm_same", 0, 0, ARM | DIS | V | Q | E, 1, 0, 1, 0, 0, 0, 0);
        add("clear_arm_idle", 0, 0, CLR | ARM | V, 0, 0, 0, 0, 0, 0, 1);
        add("ts_p1", 0, 0, V | R | E, 1, 0, 1, 0, 0, 0, 1);
        add("ts_p2", 0, 0, V | Q | E, 2, 0, 2, 0, 0, 0, 1);
        add("ts_f1", 0, 0, V | E,     2, 1, 3, 2, 1, 0, 1);
        add("ts_f2", 0, 0, V | Q | R, 2, 2, 4, 2, 1, 0, 1);
        add("disarm_fail_irq", 0, 0, DIS | V, 2, 3, 5, 2, 1, 1, 0);

        // Stop-on-fail configuration
        add("halt_arm", 1, 1, ARM, 0, 0, 0, 0, 0, 0, 1);
        add("halt_p1", 1, 0, V | Q | E, 1, 0, 1, 0, 0, 0, 1);
        add("halt_p2", 1, 0, V | R | E, 2, 0, 2, 0, 0, 0, 1);
        add("halt_fail", 1, 0, V,       2, 1, 3, 2, 1, 0, 2);
        add("halt_frozen_f", 1, 0, V,   2, 1, 3, 2, 1, 0, 2);
        add("halt_frozen_p", 1, 0, V | Q | E, 2, 1, 3, 2, 1, 0, 2);
        add("halt_rearm", 1, 0, ARM | V, 2, 1, 3, 2, 1, 0, 1);
        add("halt_resume", 1, 0, V | Q | E, 3, 1, 4, 2, 1, 0, 1);
        add("halt_again", 1, 0, V | E, 3, 2, 5, 2, 1, 0, 2);
        add("halt_clear", 1, 0, CLR, 0, 0, 0, 0, 0, 0, 2);
        add("halt_disarm", 1, 0, DIS, 0, 0, 0, 0, 0, 0, 0);

        // 4-bit counters: pass and fail saturation
        add("sat_arm", 2, 1, ARM, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 20; k++)
            add("sat_pass", 2, 0, V | Q | E, (k > 15) ? 15 : k, 0, k, 0, 0, 0, 1);
        for (int k = 1; k <= 20; k++)
            add("sat_fail", 2, 0, V, 15, (k > 15) ? 15 : k, 20 + k, 20, 1, k >= 3, 1);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            exp_q.push_back(tbl[i]);
            drive(tbl[i].in);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check(e.name, actual(e.sel), e.exp);
        end

        // Asynchronous reset in the middle of a run
        do_reset();
        drive(ARM);
        @(posedge clk); #1;
        drive(V | Q | E);
        @(posedge clk); #1;
        drive(V);
        @(posedge clk); #1;
        check("run_before_reset", actual(0), pack(1, 1, 2, 1, 1, 0, 1));
        rst_n = 1'b0;
        #2;
        check("async_reset_now", actual(0), pack(0, 0, 0, 0, 0, 0, 0));
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", actual(0), pack(0, 0, 0, 0, 0, 0, 0));
        drive(7'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qr_check_monitor.md
# qr_check_monitor

Downstream consumer of the `valid`/`q`/`r`/`en` request interface. It samples the interface on every rising clock edge and classifies each `valid` cycle: the cycle passes when `(q | r) & en` is true, and fails otherwise. It keeps saturating pass, fail and cycle counters, records a timestamp for the first failure, and raises an interrupt after a run of consecutive failures. It gives software and the bench a synthesizable scoreboard for the same rule that the interface assertion checks.

## Interface
- `CNT_W`, 16: width of the pass, fail and consecutive-fail counters.
- `TS_W`, 32: width of the free-running cycle counter and of the failure timestamp.
- `FAIL_THRESH`, 3: number of consecutive failures that asserts `fail_irq`. Legal range is 1 to 2^CNT_W-1.
- `STOP_ON_FAIL`, 0: when 1, the first failure moves the block to HALT.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: the interface qualifier for the current cycle.
- `q` in 1: request source q.
- `r` in 1: request source r.
- `en` in 1: enable term.
- `arm` in 1: synchronous pulse that starts monitoring.
- `disarm` in 1: synchronous pulse that stops monitoring.
- `clear` in 1: synchronous pulse that zeroes all counters and flags.
- `pass_cnt` out CNT_W: count of passing `valid` cycles.
- `fail_cnt` out CNT_W: count of failing `valid` cycles.
- `cycle_cnt` out TS_W: number of cycles spent in RUN.
- `first_fail_ts` out TS_W: value of `cycle_cnt` at the first failure.
- `fail_seen` out 1: sticky flag, set at the first failure.
- `fail_irq` out 1: sticky flag, set when the consecutive-failure count reaches `FAIL_THRESH`.
- `state` out 2: current state. IDLE=0, RUN=1, HALT=2.

## Operation
- **Classification**, evaluated only in RUN when `valid`=1:
  - pass = `(q | r) & en`.
  - fail = `!((q | r) & en)`.
  - Cycles with `valid`=0 are neither pass nor fail.
- **State machine**:
  - IDLE→RUN on `arm`.
  - RUN→IDLE on `disarm`.
  - RUN→HALT on a failure when `STOP_ON_FAIL`=1.
  - HALT→IDLE on `disarm`.
  - HALT→RUN on `arm`. Counters keep their values.
  - `arm` and `disarm` asserted together: `disarm` wins.
- **Counters in RUN**:
  - `cycle_cnt` increments every cycle, including the cycle with `valid`=0 and the failing cycle that causes RUN→HALT.
  - A pass increments `pass_cnt` and zeroes the internal consecutive-fail counter `cfail`.
  - A fail increments `fail_cnt` and `cfail`.
- **Saturation**: every counter, including `cfail`, saturates at its all-ones value and never wraps.
- **First failure**: on the first failure while `fail_seen`=0, `first_fail_ts` captures the pre-increment `cycle_cnt` and `fail_seen` sets to 1. Later failures do not change either output.
- **Interrupt**: `fail_irq` sets when a failure makes `cfail` equal to `FAIL_THRESH`. It stays set until `clear` or reset.
- **Clear**: `clear` zeroes `pass_cnt`, `fail_cnt`, `cycle_cnt`, `cfail`, `first_fail_ts`, `fail_seen` and `fail_irq`.
  - The state does not change on `clear`.
  - `clear` takes priority over any same-cycle classification. The sample in that cycle is discarded.
  - `clear` together with `arm` in IDLE: counters clear and the state moves to RUN in the same edge.
- **Outside RUN**: in IDLE and HALT, no counter or flag changes except through `clear` or reset.

## Timing
- **Reset**: while `rst_n`=0, all outputs are 0 and `state`=IDLE. Reset acts immediately and does not wait for a clock edge.
  - Reset in the middle of a run discards all history.
  - After `rst_n` rises, the block stays in IDLE until an `arm` pulse.
- **Sampling and latency**: inputs are sampled at rising edge N. The resulting counter, flag and state updates are visible after edge N, so the latency is one cycle.
- **Arm edge**: the `valid` sample taken at the same edge as `arm` is not classified, because the state is still IDLE at that edge. Classification starts at the next edge.
- **Disarm edge**: the sample taken at the same edge as `disarm` is still classified, and `cycle_cnt` still increments at that edge. The state is RUN during that edge.
- **Halt edge**: the failing sample that causes RUN→HALT is counted, and `fail_seen` and `first_fail_ts` update at that same edge.
- **Interrupt timing**: `fail_irq` rises at the edge that samples the `FAIL_THRESH`-th consecutive failure.
- **Outputs**: all outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Reset and idle**: reset, then drive `valid`=1, `q`=`r`=`en`=0 for 5 cycles without `arm`.
  - Required: all counters 0, `fail_seen`=0, `state`=0.
- **Mixed sequence**: `arm`, then apply `valid`=1 with (`q`,`r`,`en`) = (0,1,0), (1,0,0), (0,1,1), (1,0,1), (1,1,1).
  - Required: `pass_cnt`=3, `fail_cnt`=2, `first_fail_ts`=0, `fail_seen`=1, `fail_irq`=0.
- **Interrupt and clear**: `FAIL_THRESH`=3; sequence fail, fail, pass, fail, fail, fail.
  - Required: `fail_irq` rises after the 6th sample and not earlier.
  - Then a `clear` pulse. Required: all counters and flags read 0 and `state` stays RUN.
- **Stop on failure**: `STOP_ON_FAIL`=1; `arm`, 2 passes, then 1 fail.
  - Required: `state`=2, `fail_cnt`=1, `cycle_cnt`=3.
  - Further samples leave the counters unchanged.
  - Then `arm`: the state returns to RUN with counters kept.
- **Saturation**: `CNT_W`=4; 20 passing cycles.
  - Required: `pass_cnt` holds at 15.
- **Simultaneous controls and async reset**:
  - `arm`+`disarm` in the same cycle: required `state` stays IDLE.
  - `rst_n` low for half a clock in the middle of RUN: required outputs read 0 before the next rising edge.
